// File: rtl/sump_cmd_rx.sv
// SUMP command framer: turns the UART byte stream into complete short
// (1-byte) or long (opcode + 4 argument bytes) commands for the decoder.
module sump_cmd_rx #(
  parameter  int unsigned P_TIMEOUT = 100000,
  localparam int unsigned P_CNT_W   = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_dat_i,
  input  logic        rx_vld_i,
  output logic        stb_o,
  output logic [7:0]  opc_o,
  output logic [31:0] cmd_o,
  output logic        lng_o,
  output logic        tmo_o
);

  typedef enum logic {
    S_IDLE,
    S_ARGS
  } state_t;

  localparam logic [P_CNT_W-1:0] TMO_LIMIT = P_CNT_W'(P_TIMEOUT);

  state_t              state_q,    state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [P_CNT_W-1:0]  tmo_cnt_q,  tmo_cnt_d;
  logic [7:0]          opc_lat_q,  opc_lat_d;
  logic [31:0]         arg_q,      arg_d;
  logic                stb_q,      stb_d;
  logic                tmo_q,      tmo_d;
  logic [7:0]          opc_q,      opc_d;
  logic [31:0]         cmd_q,      cmd_d;
  logic                lng_q,      lng_d;

  // Next-state logic: frame bytes, assemble the argument and watch for stalls.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    opc_lat_d  = opc_lat_q;
    arg_d      = arg_q;
    stb_d      = 1'b0;
    tmo_d      = 1'b0;
    opc_d      = opc_q;
    cmd_d      = cmd_q;
    lng_d      = lng_q;

    case (state_q)
      S_IDLE: begin
        if (rx_vld_i) begin
          if (!rx_dat_i[7]) begin
            stb_d = 1'b1;
            opc_d = rx_dat_i;
            cmd_d = 32'h0;
            lng_d = 1'b0;
          end else begin
            opc_lat_d  = rx_dat_i;
            arg_d      = 32'h0;
            byte_cnt_d = 2'd0;
            tmo_cnt_d  = '0;
            state_d    = S_ARGS;
          end
        end
      end

      S_ARGS: begin
        if (rx_vld_i) begin
          // Any byte here is argument data, even with bit 7 set; a byte
          // arriving on the timeout threshold cycle still wins.
          arg_d[{byte_cnt_q, 3'b000} +: 8] = rx_dat_i;
          tmo_cnt_d = '0;
          if (byte_cnt_q == 2'd3) begin
            stb_d      = 1'b1;
            opc_d      = opc_lat_q;
            cmd_d      = {rx_dat_i, arg_q[23:0]};
            lng_d      = 1'b1;
            byte_cnt_d = 2'd0;
            state_d    = S_IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (P_TIMEOUT != 0) begin
          if (tmo_cnt_q == TMO_LIMIT) begin
            tmo_d      = 1'b1;
            tmo_cnt_d  = '0;
            byte_cnt_d = 2'd0;
            state_d    = S_IDLE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + P_CNT_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      tmo_cnt_q  <= '0;
      opc_lat_q  <= 8'h0;
      arg_q      <= 32'h0;
      stb_q      <= 1'b0;
      tmo_q      <= 1'b0;
      opc_q      <= 8'h0;
      cmd_q      <= 32'h0;
      lng_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      opc_lat_q  <= opc_lat_d;
      arg_q      <= arg_d;
      stb_q      <= stb_d;
      tmo_q      <= tmo_d;
      opc_q      <= opc_d;
      cmd_q      <= cmd_d;
      lng_q      <= lng_d;
    end
  end

  assign stb_o = stb_q;
  assign tmo_o = tmo_q;
  assign opc_o = opc_q;
  assign cmd_o = cmd_q;
  assign lng_o = lng_q;

endmodule
